// File: rtl/adc_axis_framer.sv
// Dual-channel ADC sample framer with an AXI4-Stream output.
// Each accepted strobe becomes one 32-bit beat {0, or_1, data_1, 0, or_0, data_0}.
// Beats are grouped into frames of FRAME_LEN with tlast on the final beat.
// A small FIFO decouples the sample strobe from the stream handshake.
// Samples that find the FIFO full are dropped, counted, and flagged on the next beat through tuser.
module adc_axis_framer #(
  parameter int DATA_W     = 14,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data_0,
  input  logic [DATA_W-1:0] smp_data_1,
  input  logic              smp_or_0,
  input  logic              smp_or_1,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_beatCnt;
  logic [CW-1:0] w_cntNext;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [33:0]   r_mem [FIFO_DEPTH];
  logic [15:0]   r_dropCnt;
  logic          r_pendDrop;

  logic          w_empty;
  logic          w_full;
  logic          w_read;
  logic          w_space;
  logic          w_accept;
  logic          w_write;
  logic          w_drop;
  logic          w_isLast;
  logic [31:0]   w_packed;
  logic [33:0]   w_head;

  // The extra pointer bit separates a full FIFO from an empty one when the index bits match.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_read  = m_axis_tvalid && m_axis_tready;

  // A read in the same cycle frees a slot, so a write into a full FIFO still succeeds.
  assign w_space = !w_full || w_read;

  // IDLE only listens when enabled. RUN keeps taking samples while a partial frame is open.
  // FLUSH always takes samples until the frame closes.
  assign w_accept = (r_state == ST_IDLE) ? enable :
                    (r_state == ST_RUN)  ? (enable || (r_beatCnt != '0)) : 1'b1;

  assign w_write  = smp_valid && w_accept && w_space;
  assign w_drop   = smp_valid && w_accept && !w_space;
  assign w_isLast = (r_beatCnt == LAST_BEAT);
  assign w_cntNext = w_write ? (w_isLast ? '0 : r_beatCnt + CW'(1)) : r_beatCnt;

  assign w_packed = {16'({smp_or_1, smp_data_1}), 16'({smp_or_0, smp_data_0})};
  assign w_head   = r_mem[r_rdPtr[AW-1:0]];

  // An empty FIFO presents all-zero sideband and data, which also covers the reset state.
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? 32'd0 : w_head[31:0];
  assign m_axis_tlast  = w_empty ? 1'b0  : w_head[32];
  assign m_axis_tuser  = w_empty ? 1'b0  : w_head[33];
  assign drop_cnt      = r_dropCnt;
  assign busy          = (r_state != ST_IDLE) || !w_empty;

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode. A frame that is still open when enable falls is finished in FLUSH.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable && smp_valid) begin
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_stateNext = (w_cntNext != '0) ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (w_write && w_isLast) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Beat position within the current frame. It advances only on accepted writes.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_beatCnt <= '0;
    end else begin
      r_beatCnt <= w_cntNext;
    end
  end

  // FIFO pointers. Both pointers wrap naturally modulo twice the depth.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_read) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
    end
  end

  // FIFO storage. The contents do not need clearing, because the pointers decide what is visible.
  always_ff @(posedge clk_in) begin
    if (w_write) begin
      r_mem[r_wrPtr[AW-1:0]] <= {r_pendDrop, w_isLast, w_packed};
    end
  end

  // Drop accounting: a saturating counter, plus a flag that marks the next written beat.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_dropCnt  <= '0;
      r_pendDrop <= 1'b0;
    end else begin
      if (w_drop && (r_dropCnt != 16'hFFFF)) begin
        r_dropCnt <= r_dropCnt + 16'd1;
      end
      if (w_drop) begin
        r_pendDrop <= 1'b1;
      end else if (w_write) begin
        r_pendDrop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_axis_framer.sv
// Self-checking bench for adc_axis_framer, built with short frames so that frame boundaries occur often.
module tb_adc_axis_framer;

   localparam int DW    = 14;
   localparam int FL    = 4;
   localparam int DEPTH = 16;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          enable;
   logic          smp_valid;
   logic [DW-1:0] smp_data_0;
   logic [DW-1:0] smp_data_1;
   logic          smp_or_0;
   logic          smp_or_1;
   logic [31:0]   m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic [15:0]   drop_cnt;
   logic          busy;

   int checks = 0;
   int passes = 0;

   always #5 clk_in = ~clk_in;

   adc_axis_framer #(.DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in(clk_in), .reset(reset), .enable(enable), .smp_valid(smp_valid),
      .smp_data_0(smp_data_0), .smp_data_1(smp_data_1),
      .smp_or_0(smp_or_0), .smp_or_1(smp_or_1),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .drop_cnt(drop_cnt), .busy(busy)
   );

   // Reference model: expected beats waiting in the output buffer, and the framing status.
   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        user;
   } beat_t;

   beat_t       modelQ[$];
   int          modelPos      = 0;
   bit          modelFraming  = 0;
   bit          modelStopping = 0;
   bit          modelPend     = 0;
   logic [15:0] modelDrops    = 16'd0;

   typedef struct {
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          or0;
      logic          or1;
      logic [31:0]   expData;
      logic          expLast;
      logic          expUser;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [31:0] packBeat(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                            input logic o0, input logic o1);
      return {1'b0, o1, d1, 1'b0, o0, d0};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Drives one cycle of inputs and returns 1 time unit after the following rising edge.
   task automatic applyStimulus(input logic en, input logic v, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic o0, input logic o1);
      enable     = en;
      smp_valid  = v;
      smp_data_0 = d0;
      smp_data_1 = d1;
      smp_or_0   = o0;
      smp_or_1   = o1;
      @(posedge clk_in);
      #1;
   endtask

   // Model step, evaluated on the values present at each rising edge.
   task automatic modelStep();
      bit rd;
      bit space;
      bit considered;
      beat_t b;
      if (reset) begin
         modelQ.delete();
         modelPos      = 0;
         modelFraming  = 0;
         modelStopping = 0;
         modelPend     = 0;
         modelDrops    = 16'd0;
         return;
      end
      rd         = (modelQ.size() > 0) && m_axis_tready;
      space      = (modelQ.size() < DEPTH) || rd;
      considered = smp_valid && (modelFraming ? (enable || modelPos != 0) : enable);
      if (rd) void'(modelQ.pop_front());
      if (considered) begin
         if (space) begin
            b.data = packBeat(smp_data_0, smp_data_1, smp_or_0, smp_or_1);
            b.last = (modelPos == FL - 1);
            b.user = modelPend;
            modelQ.push_back(b);
            modelPend = 0;
            modelPos  = (modelPos + 1) % FL;
         end else begin
            modelPend = 1;
            if (modelDrops != 16'hFFFF) modelDrops = modelDrops + 16'd1;
         end
      end
      if (!modelFraming) begin
         if (enable && smp_valid) begin
            modelFraming  = 1;
            modelStopping = 0;
         end
      end else begin
         if (!enable) modelStopping = 1;
         if (modelStopping && modelPos == 0) begin
            modelFraming  = 0;
            modelStopping = 0;
         end
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   task automatic checkCycle();
      bit valid;
      valid = (modelQ.size() > 0);
      checkOutput("tvalid", 32'(m_axis_tvalid), 32'(valid));
      if (valid) begin
         checkOutput("tdata", m_axis_tdata, modelQ[0].data);
         checkOutput("tlast", 32'(m_axis_tlast), 32'(modelQ[0].last));
         checkOutput("tuser", 32'(m_axis_tuser), 32'(modelQ[0].user));
      end
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(modelDrops));
      checkOutput("busy", 32'(busy), 32'(modelFraming || valid));
   endtask

   initial forever begin
      @(posedge clk_in);
      modelStep();
   end

   initial forever begin
      @(negedge clk_in);
      checkCycle();
   end

   initial begin
      logic [31:0] firstHead;
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;

      for (int k = 0; k < 12; k++) begin
         vecs[k].d0      = DW'(k);
         vecs[k].d1      = DW'(100 + k);
         vecs[k].or0     = (k == 10);
         vecs[k].or1     = (k == 8);
         vecs[k].expData = (32'(100 + k) << 16) | 32'(k)
                         | ((k == 8)  ? 32'h4000_0000 : 32'h0)
                         | ((k == 10) ? 32'h0000_4000 : 32'h0);
         vecs[k].expLast = ((k % FL) == FL - 1);
         vecs[k].expUser = 1'b0;
      end

      reset = 1'b1;
      m_axis_tready = 1'b1;
      applyStimulus(0, 0, '0, '0, 0, 0);
      applyStimulus(0, 0, '0, '0, 0, 0);
      checkOutput("reset tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("reset tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("reset tuser", 32'(m_axis_tuser), 32'd0);
      checkOutput("reset tdata", m_axis_tdata, 32'd0);
      checkOutput("reset drop_cnt", 32'(drop_cnt), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      reset = 1'b0;
      applyStimulus(0, 0, '0, '0, 0, 0);

      $display("[TB] table vectors: basic framing and overrange bits");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, 1, vecs[i].d0, vecs[i].d1, vecs[i].or0, vecs[i].or1);
         checkOutput($sformatf("vec%0d tvalid", i), 32'(m_axis_tvalid), 32'd1);
         checkOutput($sformatf("vec%0d tdata", i), m_axis_tdata, vecs[i].expData);
         checkOutput($sformatf("vec%0d tlast", i), 32'(m_axis_tlast), 32'(vecs[i].expLast));
         checkOutput($sformatf("vec%0d tuser", i), 32'(m_axis_tuser), 32'(vecs[i].expUser));
         if (i == 0) checkOutput("beat0 literal", m_axis_tdata, 32'h0064_0000);
      end
      applyStimulus(1, 0, '0, '0, 0, 0);
      applyStimulus(0, 0, '0, '0, 0, 0);
      checkOutput("idle after frames busy", 32'(busy), 32'd0);

      $display("[TB] overflow with tready held low");
      m_axis_tready = 1'b0;
      firstHead = packBeat(14'd1, 14'd2, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (i == 0) applyStimulus(1, 1, 14'd1, 14'd2, 0, 0);
         else        applyStimulus(1, 1, DW'($urandom), DW'($urandom), 0, 0);
      end
      checkOutput("overflow drop_cnt", 32'(drop_cnt), 32'd4);
      checkOutput("overflow head tdata", m_axis_tdata, firstHead);
      checkOutput("overflow head tuser", 32'(m_axis_tuser), 32'd0);
      m_axis_tready = 1'b1;
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, '0, '0, 0, 0);
      checkOutput("drained tvalid", 32'(m_axis_tvalid), 32'd0);
      applyStimulus(1, 1, 14'd7, 14'd8, 0, 0);
      checkOutput("post-drop tuser", 32'(m_axis_tuser), 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, DW'($urandom), DW'($urandom), 0, 0);
      checkOutput("post-drop next tuser", 32'(m_axis_tuser), 32'd0);
      applyStimulus(0, 0, '0, '0, 0, 0);
      applyStimulus(0, 0, '0, '0, 0, 0);

      $display("[TB] enable falls mid-frame");
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, DW'(i), DW'(i), 0, 0);
      applyStimulus(0, 0, '0, '0, 0, 0);
      checkOutput("flush busy", 32'(busy), 32'd1);
      applyStimulus(0, 1, 14'd33, 14'd44, 0, 0);
      checkOutput("flush tlast", 32'(m_axis_tlast), 32'd1);
      checkOutput("flush tdata", m_axis_tdata, packBeat(14'd33, 14'd44, 1'b0, 1'b0));
      applyStimulus(0, 0, '0, '0, 0, 0);
      checkOutput("after flush busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, DW'($urandom), DW'($urandom), 0, 0);
         checkOutput("ignored in idle tvalid", 32'(m_axis_tvalid), 32'd0);
      end

      $display("[TB] reset with beats buffered");
      m_axis_tready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(1, 1, DW'(i + 50), DW'(i), 0, 0);
      checkOutput("buffered tvalid", 32'(m_axis_tvalid), 32'd1);
      reset = 1'b1;
      applyStimulus(1, 0, '0, '0, 0, 0);
      checkOutput("mid reset tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("mid reset tdata", m_axis_tdata, 32'd0);
      checkOutput("mid reset busy", 32'(busy), 32'd0);
      checkOutput("mid reset drop_cnt", 32'(drop_cnt), 32'd0);
      reset = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < FL; i++) begin
         applyStimulus(1, 1, DW'(i), DW'(i), 0, 0);
         checkOutput($sformatf("after reset beat%0d tlast", i), 32'(m_axis_tlast), 32'(i == FL - 1));
      end
      applyStimulus(0, 0, '0, '0, 0, 0);

      $display("[TB] random data with 50/5 tready and a strobe every 2 cycles");
      for (int c = 0; c < 600; c++) begin
         m_axis_tready = ((c % 55) < 50);
         ra = DW'($urandom);
         rb = DW'($urandom);
         applyStimulus(1, (c % 2) == 0, ra, rb, 1'($urandom), 1'($urandom));
      end
      m_axis_tready = 1'b1;
      for (int i = 0; i < FL; i++) applyStimulus(0, 1, DW'($urandom), DW'($urandom), 0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, '0, '0, 0, 0);
      checkOutput("throttled drop_cnt", 32'(drop_cnt), 32'd0);
      checkOutput("throttled busy", 32'(busy), 32'd0);

      $display("[TB] fully random traffic");
      enable = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) enable = ~enable;
         m_axis_tready = ($urandom_range(0, 3) != 0) ? ((c / 64) % 2 == 0) : 1'($urandom);
         applyStimulus(enable, 1'($urandom), DW'($urandom), DW'($urandom),
                       1'($urandom), 1'($urandom));
      end
      m_axis_tready = 1'b1;
      for (int i = 0; i < FL; i++) applyStimulus(0, 1, DW'($urandom), DW'($urandom), 0, 0);
      for (int i = 0; i < 30; i++) applyStimulus(0, 0, '0, '0, 0, 0);
      checkOutput("final busy", 32'(busy), 32'd0);
      checkOutput("final tvalid", 32'(m_axis_tvalid), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
